// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, word/byte RAM access.
// Latency: response pulse registered WAIT_CYCLES edges after acceptance; load data WAIT_CYCLES+1 cycles after request.
// Backpressure: req_ready_o low while busy (WAIT/RESP); responses cannot be stalled.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_byte_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [29:0] DEPTH_W   = 30'(DEPTH);
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic        byte_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    // Uninitialised storage; never touched by reset.
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          commit;
    logic          c_write;
    logic          c_byte;
    logic [31:0]   c_addr;
    logic [31:0]   c_wdata;
    logic          c_err;
    logic [AW-1:0] c_idx;
    logic [4:0]    c_shift;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [31:0]   rd_data;
    logic [31:0]   wr_word;

    assign req_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign accept       = req_valid_i & req_ready_o;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

    // Select the request being committed (live inputs only for zero wait states) and decode access.
    always_comb begin
        commit = 1'b0;
        if (state_q == S_IDLE) begin
            commit = accept & ZERO_WAIT;
        end else if (state_q == S_WAIT) begin
            commit = (cnt_q == 4'd0);
        end

        if (state_q == S_IDLE) begin
            c_write = req_write_i;
            c_byte  = req_byte_i;
            c_addr  = req_addr_i;
            c_wdata = req_wdata_i;
        end else begin
            c_write = write_q;
            c_byte  = byte_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
        end

        c_err   = (c_addr[31:2] >= DEPTH_W) | (~c_byte & (c_addr[1:0] != 2'b00));
        c_idx   = c_addr[AW+1:2];
        c_shift = {c_addr[1:0], 3'b000};

        rd_word = mem[c_idx];
        rd_byte = rd_word[c_shift +: 8];
        rd_data = c_byte ? {24'b0, rd_byte} : rd_word;

        wr_word = c_wdata;
        if (c_byte) begin
            wr_word = rd_word;
            wr_word[c_shift +: 8] = c_wdata[7:0];
        end
    end

    // RAM write on the edge entering RESP; an in-flight store is dropped while reset is asserted.
    always_ff @(posedge clk) begin
        if (commit & c_write & ~c_err & ~reset) begin
            mem[c_idx] <= wr_word;
        end
    end

    // Control FSM plus registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            byte_q       <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= commit;
            if (commit) begin
                resp_rdata_q <= (c_write | c_err) ? 32'd0 : rd_data;
                resp_err_q   <= c_err;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        write_q <= req_write_i;
                        byte_q  <= req_byte_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        cnt_q   <= CNT_INIT;
                        state_q <= ZERO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (2 wait states and 0 wait states).
// Stimulus tasks push expected responses; a negedge monitor pops and compares.
// Reference memory is a byte array updated at issue time.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int W0    = 2;
    localparam int W1    = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]  rst;
    logic [1:0]  vld;
    logic [1:0]  wr;
    logic [1:0]  bt;
    logic [31:0] adr [2];
    logic [31:0] wd  [2];

    wire         rdy0, rdy1, rv0, rv1, er0, er1, bz0, bz1;
    wire  [31:0] rd0, rd1;
    wire  [1:0]  rdy  = {rdy1, rdy0};
    wire  [1:0]  rvld = {rv1, rv0};
    wire  [1:0]  rerr = {er1, er0};
    wire  [1:0]  bsy  = {bz1, bz0};
    wire  [31:0] rdat [2];
    assign rdat[0] = rd0;
    assign rdat[1] = rd1;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset(rst[0]),
        .req_valid_i(vld[0]), .req_ready_o(rdy0), .req_write_i(wr[0]), .req_byte_i(bt[0]),
        .req_addr_i(adr[0]), .req_wdata_i(wd[0]),
        .resp_valid_o(rv0), .resp_rdata_o(rd0), .resp_err_o(er0), .busy_o(bz0)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset(rst[1]),
        .req_valid_i(vld[1]), .req_ready_o(rdy1), .req_write_i(wr[1]), .req_byte_i(bt[1]),
        .req_addr_i(adr[1]), .req_wdata_i(wd[1]),
        .resp_valid_o(rv1), .resp_rdata_o(rd1), .resp_err_o(er1), .busy_o(bz1)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   last_acc [2];
    logic [7:0] mm [2][DEPTH*4];

    function automatic int wc(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte-addressed reference memory: returns expected error/data and applies the store.
    task automatic model(input int d, input bit w, input bit b, input logic [31:0] a,
                         input logic [31:0] wdat, output bit err, output logic [31:0] rdata);
        int base;
        err   = ((a >> 2) >= DEPTH) || (!b && (a % 4) != 0);
        rdata = 32'd0;
        if (!err) begin
            base = int'(a);
            if (w) begin
                if (b) mm[d][base] = wdat[7:0];
                else for (int i = 0; i < 4; i++) mm[d][base + i] = wdat[8*i +: 8];
            end else begin
                if (b) rdata = {24'd0, mm[d][base]};
                else rdata = {mm[d][base+3], mm[d][base+2], mm[d][base+1], mm[d][base]};
            end
        end
    endtask

    // Present a request, wait for acceptance, then record the expected response.
    task automatic issue(input int d, input bit w, input bit b, input logic [31:0] a,
                         input logic [31:0] wdat, input bit keep = 1'b0, input bit exp_resp = 1'b1,
                         input bit lit = 1'b0, input bit lerr = 1'b0, input logic [31:0] lrd = 32'd0);
        exp_t        e;
        bit          merr;
        logic [31:0] mrd;
        int          n;
        @(negedge clk);
        wr[d] = w; bt[d] = b; adr[d] = a; wd[d] = wdat; vld[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst%0d: req_ready stayed 0, expected 1", d);
            vld[d] = 1'b0;
            return;
        end
        chk($sformatf("busy_idle%0d", d), {31'd0, bsy[d]}, 32'd0);
        @(posedge clk);
        #1;
        last_acc[d] = cyc;
        if (!keep) vld[d] = 1'b0;
        if (exp_resp) begin
            model(d, w, b, a, wdat, merr, mrd);
            e.err   = lit ? lerr : merr;
            e.rdata = lit ? lrd : mrd;
            e.acc   = cyc;
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic rnd_op(input int d, input bit keep);
        logic [31:0] a;
        bit          w, b;
        int          k;
        k = $urandom_range(0, 9);
        w = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        if (k < 8) a = $urandom_range(0, DEPTH*4 - 1);
        else if (k == 8) a = $urandom_range(DEPTH*4, DEPTH*4 + 64);
        else a = $urandom;
        if (!b && k < 6) a[1:0] = 2'b00;
        issue(d, w, b, a, $urandom, keep);
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (((d == 0 ? q0.size() : q1.size()) != 0 || !rdy[d]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout inst%0d: %0d responses missing, expected 0", d,
                     (d == 0 ? q0.size() : q1.size()));
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (rvld[d] === 1'b1) begin
                have = 1'b0;
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL unexpected_resp inst%0d: resp_valid=1 rdata=0x%08h, expected no response",
                             d, rdat[d]);
                end else begin
                    chk($sformatf("resp_err%0d", d), {31'd0, rerr[d]}, {31'd0, e.err});
                    chk($sformatf("resp_rdata%0d", d), rdat[d], e.rdata);
                    chk($sformatf("resp_latency%0d", d), 32'(cyc - e.acc), 32'(wc(d)));
                    chk($sformatf("busy_resp%0d", d), {31'd0, bsy[d]}, 32'd1);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lo, g, p;
        rst = 2'b11; vld = 2'b00; wr = 2'b00; bt = 2'b00;
        adr[0] = 0; adr[1] = 0; wd[0] = 0; wd[1] = 0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ready%0d", d), {31'd0, rdy[d]}, 32'd1);
            chk($sformatf("rst_valid%0d", d), {31'd0, rvld[d]}, 32'd0);
            chk($sformatf("rst_rdata%0d", d), rdat[d], 32'd0);
            chk($sformatf("rst_err%0d", d), {31'd0, rerr[d]}, 32'd0);
            chk($sformatf("rst_busy%0d", d), {31'd0, bsy[d]}, 32'd0);
        end
        rst = 2'b00;

        // Give both RAMs known contents.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) issue(d, 1'b1, 1'b0, 32'(i * 4), $urandom);
        wait_idle(0);
        wait_idle(1);

        // Directed word/byte/error cases, 2 wait states.
        issue(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        lo = 0; g = 0;
        @(negedge clk);
        while (!rdy[0] && g < 50) begin lo++; g++; @(negedge clk); end
        chk("ready_low_cycles", 32'(lo), 32'd3);
        issue(0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF);
        issue(0, 1'b1, 1'b1, 32'h11, 32'h000000AB, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        issue(0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADABEF);
        issue(0, 1'b0, 1'b1, 32'h13, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h000000DE);
        issue(0, 1'b1, 1'b0, 32'h12, 32'h12345678, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
        issue(0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADABEF);
        issue(0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0);
        issue(0, 1'b0, 1'b1, 32'hFF, 32'd0);
        wait_idle(0);

        // Reset while a store sits in WAIT: store must be lost, no response.
        issue(0, 1'b1, 1'b0, 32'h20, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        wait_idle(0);
        issue(0, 1'b1, 1'b0, 32'h20, 32'h22222222, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        #1;
        chk("rst_mid_ready", {31'd0, rdy[0]}, 32'd1);
        chk("rst_mid_valid", {31'd0, rvld[0]}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_ready", {31'd0, rdy[0]}, 32'd1);
            chk("rst_hold_valid", {31'd0, rvld[0]}, 32'd0);
        end
        rst[0] = 1'b0;
        issue(0, 1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11111111);
        wait_idle(0);

        // Zero wait states, req_valid held high across requests.
        issue(1, 1'b1, 1'b0, 32'h04, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        p = last_acc[1];
        issue(1, 1'b0, 1'b0, 32'h04, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFEF00D);
        chk("b2b_spacing", 32'(last_acc[1] - p), 32'd2);
        for (int i = 0; i < 8; i++) begin
            p = last_acc[1];
            rnd_op(1, i != 7);
            chk("b2b_spacing", 32'(last_acc[1] - p), 32'd2);
        end
        wait_idle(1);

        // Randomised traffic with idle gaps on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                rnd_op(d, 1'b0);
            end
            wait_idle(d);
        end

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
